// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshakes and a 2-entry skid buffer.
// Optional statistics counters are enabled by defining DECODE_STAGE_STATS_EN.
module decode_stage #(
    parameter int OP_W   = 8,
    parameter int REG_W  = 8,
    parameter int IMM_W  = 32,
    parameter int NUM_OP = 200,
    localparam int INSTR_W = 2*REG_W + OP_W + 8 + IMM_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OP_W-1:0]    op_o,
    output logic [REG_W-1:0]   dst_o,
    output logic [REG_W-1:0]   src_o,
    output logic [1:0]         mod_mem_o,
    output logic [1:0]         mod_shift_o,
    output logic [3:0]         mod_cond_o,
    output logic [IMM_W-1:0]   imm_o,
    output logic               illegal_o
`ifdef DECODE_STAGE_STATS_EN
   ,output logic [31:0]        dec_count_o,
    output logic [15:0]        illegal_count_o,
    output logic [31:0]        stall_count_o
`endif
);

    localparam int DST_LSB = OP_W;
    localparam int SRC_LSB = OP_W + REG_W;
    localparam int MOD_LSB = OP_W + 2*REG_W;
    localparam logic [OP_W:0] NUM_OP_L = (OP_W+1)'(NUM_OP);

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [IMM_W-1:0] imm;
        logic [7:0]       mod;
        logic [REG_W-1:0] src;
        logic [REG_W-1:0] dst;
        logic [OP_W-1:0]  op;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t inc;
    logic   in_ready_q, in_ready_d;
    logic   in_acc;
    logic   out_xfer;

    assign in_acc   = in_valid_i & in_ready_q;
    assign out_xfer = m_q.valid & out_ready_i;

    always_comb begin
        inc.valid   = 1'b1;
        inc.op      = instr_i[OP_W-1:0];
        inc.dst     = instr_i[DST_LSB +: REG_W];
        inc.src     = instr_i[SRC_LSB +: REG_W];
        inc.mod     = instr_i[MOD_LSB +: 8];
        inc.imm     = instr_i[INSTR_W-1 -: IMM_W];
        // mod_mem == 2'b11 is a reserved encoding.
        inc.illegal = ({1'b0, inc.op} >= NUM_OP_L) || (inc.mod[1:0] == 2'b11);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        m_d = m_q;
        s_d = s_q;
        if (flush_i) begin
            m_d = '0;
            s_d = '0;
        end else if (!m_q.valid || out_xfer) begin
            if (s_q.valid) begin
                m_d = s_q;
                s_d = '0;
            end else if (in_acc) begin
                m_d = inc;
            end else begin
                // Drained: data keeps the last delivered instruction.
                m_d.valid = 1'b0;
            end
        end else if (in_acc) begin
            s_d = inc;
        end
        in_ready_d = !s_d.valid;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: data registers are reset too, since the data outputs must read 0 after reset.
        if (rst_i) begin
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = m_q.valid;
    assign op_o        = m_q.op;
    assign dst_o       = m_q.dst;
    assign src_o       = m_q.src;
    assign mod_mem_o   = m_q.mod[1:0];
    assign mod_shift_o = m_q.mod[3:2];
    assign mod_cond_o  = m_q.mod[7:4];
    assign imm_o       = m_q.imm;
    assign illegal_o   = m_q.illegal;

`ifdef DECODE_STAGE_STATS_EN
    logic [31:0] dec_count_q, dec_count_d;
    logic [15:0] illegal_count_q, illegal_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        dec_count_d     = dec_count_q;
        illegal_count_d = illegal_count_q;
        stall_count_d   = stall_count_q;
        if (out_xfer) begin
            dec_count_d = dec_count_q + 32'd1;
            if (m_q.illegal) begin
                illegal_count_d = illegal_count_q + 16'd1;
            end
        end
        if (m_q.valid && !out_ready_i) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_count_q     <= '0;
            illegal_count_q <= '0;
            stall_count_q   <= '0;
        end else begin
            dec_count_q     <= dec_count_d;
            illegal_count_q <= illegal_count_d;
            stall_count_q   <= stall_count_d;
        end
    end

    assign dec_count_o     = dec_count_q;
    assign illegal_count_o = illegal_count_q;
    assign stall_count_o   = stall_count_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes expected decodes, monitor pops on output transfers.
module tb_decode_stage;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [1:0]  mem;
        logic [1:0]  shift;
        logic [3:0]  cond;
        logic [31:0] imm;
        logic        ill;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] instr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  op_o, dst_o, src_o;
    logic [1:0]  mod_mem_o, mod_shift_o;
    logic [3:0]  mod_cond_o;
    logic [31:0] imm_o;
    logic        illegal_o;
`ifdef DECODE_STAGE_STATS_EN
    logic [31:0] dec_count_o;
    logic [15:0] illegal_count_o;
    logic [31:0] stall_count_o;
    logic [31:0] m_dec = '0;
    logic [15:0] m_ill = '0;
    logic [31:0] m_stall = '0;
`endif

    fields_t sb[$];
    fields_t hold = '0;
    int      n_vec = 0;
    int      n_err = 0;
    logic    last_acc = 1'b0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .op_o        (op_o),
        .dst_o       (dst_o),
        .src_o       (src_o),
        .mod_mem_o   (mod_mem_o),
        .mod_shift_o (mod_shift_o),
        .mod_cond_o  (mod_cond_o),
        .imm_o       (imm_o),
        .illegal_o   (illegal_o)
`ifdef DECODE_STAGE_STATS_EN
       ,.dec_count_o     (dec_count_o),
        .illegal_count_o (illegal_count_o),
        .stall_count_o   (stall_count_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the field layout, using plain arithmetic.
    function automatic fields_t decode(input logic [63:0] ins);
        fields_t f;
        logic [7:0] mod_b;
        f.op   = 8'(ins % 256);
        f.dst  = 8'((ins >> 8) % 256);
        f.src  = 8'((ins >> 16) % 256);
        mod_b  = 8'((ins >> 24) % 256);
        f.mem  = 2'(mod_b % 4);
        f.shift = 2'((mod_b / 4) % 4);
        f.cond = 4'(mod_b / 16);
        f.imm  = 32'(ins >> 32);
        f.ill  = (f.op >= 8'd200) || (f.mem == 2'd3);
        return f;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [7:0] mod_b);
        logic [31:0] r;
        r = $urandom;
        return {$urandom, mod_b, r[15:8], r[7:0], op};
    endfunction

    task automatic cmp_fields(input string tag, input fields_t e);
        check({tag, ".op"},    64'(op_o),        64'(e.op));
        check({tag, ".dst"},   64'(dst_o),       64'(e.dst));
        check({tag, ".src"},   64'(src_o),       64'(e.src));
        check({tag, ".mem"},   64'(mod_mem_o),   64'(e.mem));
        check({tag, ".shift"}, 64'(mod_shift_o), 64'(e.shift));
        check({tag, ".cond"},  64'(mod_cond_o),  64'(e.cond));
        check({tag, ".imm"},   64'(imm_o),       64'(e.imm));
        check({tag, ".ill"},   64'(illegal_o),   64'(e.ill));
    endtask

    // Monitor: the queue holds exactly the accepted, undelivered instructions.
    always @(negedge clk) begin
        if (rst_i) begin
`ifdef DECODE_STAGE_STATS_EN
            m_dec = '0; m_ill = '0; m_stall = '0;
`endif
        end else begin
`ifdef DECODE_STAGE_STATS_EN
            check("dec_count",     64'(dec_count_o),     64'(m_dec));
            check("illegal_count", 64'(illegal_count_o), 64'(m_ill));
            check("stall_count",   64'(stall_count_o),   64'(m_stall));
`endif
            check("in_ready",  64'(in_ready_o),  64'(sb.size() < 2));
            check("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
            if (out_valid_o && sb.size() != 0) begin
                cmp_fields("out", sb[0]);
                if (out_ready_i) begin
                    hold = sb.pop_front();
`ifdef DECODE_STAGE_STATS_EN
                    m_dec++;
                    if (hold.ill) m_ill++;
`endif
                end
`ifdef DECODE_STAGE_STATS_EN
                else m_stall++;
`endif
            end else if (!out_valid_o) begin
                cmp_fields("idle", hold);
            end
        end
    end

    task automatic step(input logic v, input logic [63:0] ins, input logic rdy,
                        input logic fl = 1'b0, input logic rs = 1'b0);
        logic acc, clr;
        in_valid_i  = v;
        instr_i     = ins;
        out_ready_i = rdy;
        flush_i     = fl;
        rst_i       = rs;
        @(negedge clk);
        acc = in_valid_i && in_ready_o;
        clr = flush_i || rst_i;
        @(posedge clk);
        #1;
        if (clr) begin
            sb.delete();
            hold = '0;
        end else if (acc) begin
            sb.push_back(decode(ins));
        end
        last_acc = acc && !clr;
    endtask

    task automatic offer(input logic [63:0] ins, input logic rdy);
        int budget = 20;
        do begin
            step(1'b1, ins, rdy);
            budget--;
        end while (!last_acc && budget > 0);
        check("offer_accepted", 64'(last_acc), 64'd1);
    endtask

    initial begin
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Field split and illegal boundaries.
        step(1'b1, 64'h0000_0010_A5_03_02_01, 1'b1);
        step(1'b1, mk(8'hC8, 8'h00), 1'b1);
        step(1'b1, mk(8'hC7, 8'h03), 1'b1);
        step(1'b1, mk(8'hC7, 8'h02), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Back-to-back stream of 8.
        for (int i = 1; i <= 8; i++) step(1'b1, mk(8'(i), 8'h00), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure: 1 in M, 2 in S, 3 held at the input.
        step(1'b1, mk(8'd1, 8'h10), 1'b0);
        step(1'b1, mk(8'd2, 8'h20), 1'b0);
        step(1'b1, mk(8'd3, 8'h30), 1'b0);
        check("bp_hold3", 64'(last_acc), 64'd0);
        step(1'b1, mk(8'd3, 8'h30), 1'b0);
        check("bp_hold3b", 64'(last_acc), 64'd0);
        offer(mk(8'd3, 8'h30), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Flush with S full and a valid input in the flush cycle.
        step(1'b1, mk(8'h11, 8'h00), 1'b0);
        step(1'b1, mk(8'h12, 8'h00), 1'b0);
        step(1'b1, mk(8'h13, 8'h00), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Reset mid-stream, then 3 stalls and 5 transfers (one illegal).
        step(1'b1, mk(8'h21, 8'h00), 1'b0);
        step(1'b1, mk(8'h22, 8'h00), 1'b0);
        step(1'b1, mk(8'h23, 8'h00), 1'b1, 1'b0, 1'b1);
        step(1'b1, mk(8'd1, 8'h00), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, mk(8'd2, 8'h00), 1'b1);
        step(1'b1, mk(8'd200, 8'h00), 1'b1);
        step(1'b1, mk(8'd3, 8'h00), 1'b1);
        step(1'b1, mk(8'd4, 8'h00), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
`ifdef DECODE_STAGE_STATS_EN
        check("plan_dec",   64'(dec_count_o),     64'd5);
        check("plan_ill",   64'(illegal_count_o), 64'd1);
        check("plan_stall", 64'(stall_count_o),   64'd3);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            op = (sel == 0) ? 8'd199 : (sel == 1) ? 8'd200 : (sel == 2) ? 8'hFF : 8'($urandom);
            step($urandom_range(0, 9) < 7, mk(op, 8'($urandom)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0);
        end

        begin
            int budget = 10;
            while (sb.size() != 0 && budget > 0) begin
                step(1'b0, '0, 1'b1);
                budget--;
            end
        end
        check("drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled instruction decode stage. It sits between fetch and execute and replaces the purely combinational field splitter.
- Splits each instruction word into op, dst, src, mod (mem/shift/cond) and imm fields.
- Flags illegal encodings.
- Uses valid/ready on both sides and a 2-entry skid buffer, so it sustains 1 instruction/cycle with a registered ready.

Parameters:
- OP_W, 8, opcode field width
- REG_W, 8, width of each of the dst and src fields
- IMM_W, 32, immediate width. Instruction width INSTR_W = 2*REG_W + OP_W + 8 + IMM_W (default 64).
- NUM_OP, 200, number of defined opcodes. Any op >= NUM_OP is illegal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  drop all buffered instructions
- in_valid_i  in  1  instruction valid from fetch
- in_ready_o  out  1  stage can accept an instruction
- instr_i  in  INSTR_W  raw instruction word
- out_valid_o  out  1  decoded fields valid
- out_ready_i  in  1  execute accepts decoded fields
- op_o  out  OP_W  instr_i[OP_W-1:0]
- dst_o  out  REG_W  next REG_W bits
- src_o  out  REG_W  next REG_W bits
- mod_mem_o  out  2  mod byte bits [1:0]
- mod_shift_o  out  2  mod byte bits [3:2]
- mod_cond_o  out  4  mod byte bits [7:4]
- imm_o  out  IMM_W  top IMM_W bits of instr_i
- illegal_o  out  1  decoded instruction is illegal

Behaviour:
- Field layout, LSB first: op | dst | src | mod(8) | imm. With defaults: op [7:0], dst [15:8], src [23:16], mod [31:24], imm [63:32].
- illegal_o = (op >= NUM_OP) OR (mod_mem == 2'b11, reserved). Computed at capture and stored with the entry.
- Storage: main output register M and skid register S. Each holds all decoded fields plus a valid bit.
- Input transfer: in_valid_i & in_ready_o. Output transfer: out_valid_o & out_ready_i.
- in_ready_o is a register, equal to !S.valid. It never depends combinationally on out_ready_i.
- Latency: an instruction accepted in cycle N appears on outputs in cycle N+1 when M is empty or draining.
- Per-cycle update rules:
  - M empty, or M transferring out, with S empty: M <= incoming instruction if accepted, else M.valid <= 0.
  - M transferring out with S full: M <= S, S.valid <= 0. in_ready_o is 0 this cycle, so no input is accepted.
  - M full, not transferring, input accepted: S <= incoming; in_ready_o drops next cycle.
  - M full, not transferring, no input: hold.
- Order is strictly preserved. Accepted instructions are never duplicated or lost.
- Outputs stay stable while out_valid_o=1 and out_ready_i=0.
- flush_i: next cycle M.valid=0, S.valid=0, in_ready_o=1. An input presented in the flush cycle is discarded, even if in_ready_o=1. Flush has priority over every other event.
- Reset: out_valid_o=0, in_ready_o=1, every data output (op, dst, src, mod_*, imm, illegal) = 0. Reset mid-stream discards both entries.
- Data outputs are 0 whenever out_valid_o=0 after reset or flush. Otherwise they hold the last M contents.

Optional Feature:
- Macro DECODE_STAGE_STATS_EN.
- When defined, the block adds three outputs:
  - dec_count_o (32): increments on each output transfer.
  - illegal_count_o (16): increments on each output transfer with illegal_o=1.
  - stall_count_o (32): increments each cycle with out_valid_o=1 and out_ready_i=0.
- All three counters reset to 0 on rst_i, are not cleared by flush_i, and wrap modulo 2^width.
- When not defined, these ports and counters do not exist. Decode behaviour is identical in both builds.

Test Plan:
- Field split: instr_i=64'h0000_0010_A5_03_02_01, out_ready_i=1 -> next cycle op=01, dst=02, src=03, mod_mem=1, mod_shift=1, mod_cond=A, imm=0000_0010, illegal=0.
- Illegal detection: op=8'hC8 (200) -> illegal=1. op=8'hC7 with mod=8'h03 -> illegal=1. op=8'hC7 with mod=8'h02 -> illegal=0.
- Back-to-back stream: 8 instructions with op 1..8, in_valid_i=1 and out_ready_i=1 throughout -> out_valid_o high for 8 consecutive cycles, starting 1 cycle after the first accept, ops 1..8 in order.
- Backpressure: out_ready_i=0 while ops 1,2,3 are offered -> 1 held on outputs, 2 captured in S, in_ready_o=0 from the next cycle, 3 held at input. Release out_ready_i -> outputs 1,2,3 with no loss or duplication.
- Flush with S full, plus in_valid_i in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, and none of the three instructions is ever output.
- Reset asserted mid-stream with DECODE_STAGE_STATS_EN defined -> all outputs and counters 0. After 5 transfers (one illegal) and 3 stall cycles: dec_count_o=5, illegal_count_o=1, stall_count_o=3.
